// File: rtl/cmd_script_engine.sv
// Script sequencer: queues commands, issues each to RemoteComm, times out the reply and scores it against ACK.
// Optional STOP_ON_ERR_EN: halt in DONE on first fail/timeout, leaving the remaining script queued.
module cmd_script_engine #(
  parameter int                CMD_W   = 16,
  parameter int                RESP_W  = 8,
  parameter int                DEPTH   = 8,
  parameter int                TIMEOUT = 1000000,
  parameter logic [RESP_W-1:0] ACK     = 8'hA5,
  parameter int                CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [CMD_W-1:0]  wr_cmd,
  output logic              full,
  output logic              empty,
  input  logic              start,
  output logic [CMD_W-1:0]  cmd,
  output logic              send_cmd,
  input  logic              cmd_sent,
  input  logic              resp_rdy,
  input  logic [RESP_W-1:0] resp,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  n_pass,
  output logic [CNT_W-1:0]  n_fail,
  output logic [CNT_W-1:0]  n_tmo,
  output logic [CMD_W-1:0]  err_cmd
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

`ifdef STOP_ON_ERR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_POP, S_SEND, S_WAIT_SENT, S_WAIT_RESP, S_CHECK, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [CMD_W-1:0]  mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              push, pop;
  logic [TW-1:0]     timer;
  logic [RESP_W-1:0] resp_q;
  logic              tmo_hit;
  logic              clr_stats, do_pass, do_fail, do_tmo;
  logic              latch_resp, timer_clr, timer_inc;

  // Extra pointer bit distinguishes full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = (state == S_POP) && !empty;
  // A pop frees the slot this cycle, so a push while full is accepted alongside it.
  assign push  = wr_en && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_cmd;
  end

  assign tmo_hit = (timer == TMO_LAST) && !resp_rdy;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    clr_stats  = 1'b0;
    do_pass    = 1'b0;
    do_fail    = 1'b0;
    do_tmo     = 1'b0;
    latch_resp = 1'b0;
    timer_clr  = 1'b0;
    timer_inc  = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nx  = S_POP;
          clr_stats = 1'b1;
        end
      end
      S_POP:  state_nx = empty ? S_DONE : S_SEND;
      S_SEND: begin
        timer_clr = 1'b1;
        state_nx  = S_WAIT_SENT;
      end
      S_WAIT_SENT, S_WAIT_RESP: begin
        timer_inc = 1'b1;
        // A response arriving on the last timeout cycle still counts as a reply.
        if (resp_rdy) begin
          latch_resp = 1'b1;
          state_nx   = S_CHECK;
        end else if (tmo_hit) begin
          do_tmo   = 1'b1;
          state_nx = STOP_ON_ERR ? S_DONE : S_POP;
        end else if (state == S_WAIT_SENT && cmd_sent) begin
          state_nx = S_WAIT_RESP;
        end
      end
      S_CHECK: begin
        if (resp_q == ACK) begin
          do_pass  = 1'b1;
          state_nx = S_POP;
        end else begin
          do_fail  = 1'b1;
          state_nx = STOP_ON_ERR ? S_DONE : S_POP;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd      <= '0;
      send_cmd <= 1'b0;
      timer    <= '0;
      resp_q   <= '0;
      n_pass   <= '0;
      n_fail   <= '0;
      n_tmo    <= '0;
      err_cmd  <= '0;
    end else begin
      // Registered strobe: asserted for the first WAIT_SENT cycle, when timer is 0.
      send_cmd <= (state == S_SEND);
      if (pop) cmd <= mem[rd_ptr[AW-1:0]];
      if (timer_clr)      timer <= '0;
      else if (timer_inc) timer <= timer + 1'b1;
      if (latch_resp) resp_q <= resp;
      if (clr_stats) begin
        n_pass  <= '0;
        n_fail  <= '0;
        n_tmo   <= '0;
        err_cmd <= '0;
      end else begin
        if (do_pass && n_pass != '1) n_pass <= n_pass + 1'b1;
        if (do_fail) begin
          if (n_fail != '1) n_fail <= n_fail + 1'b1;
          err_cmd <= cmd;
        end
        if (do_tmo) begin
          if (n_tmo != '1) n_tmo <= n_tmo + 1'b1;
          err_cmd <= cmd;
        end
      end
    end
  end

  assign busy = !(state == S_IDLE || state == S_DONE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_cmd_script_engine.sv
// Directed bench for cmd_script_engine (DEPTH=8, TIMEOUT=50); acts as script source and RemoteComm.
module tb_cmd_script_engine;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [15:0] wr_cmd = '0;
  logic        full, empty;
  logic        start = 1'b0;
  logic [15:0] cmd;
  logic        send_cmd;
  logic        cmd_sent = 1'b0;
  logic        resp_rdy = 1'b0;
  logic [7:0]  resp = '0;
  logic        busy, done;
  logic [7:0]  n_pass, n_fail, n_tmo;
  logic [15:0] err_cmd;

  int n_vec = 0;
  int n_err = 0;
  int n_send = 0;
  int snap;

  cmd_script_engine #(
    .CMD_W(16), .RESP_W(8), .DEPTH(8), .TIMEOUT(50), .ACK(8'hA5), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_cmd(wr_cmd), .full(full), .empty(empty),
    .start(start), .cmd(cmd), .send_cmd(send_cmd), .cmd_sent(cmd_sent),
    .resp_rdy(resp_rdy), .resp(resp), .busy(busy), .done(done), .n_pass(n_pass),
    .n_fail(n_fail), .n_tmo(n_tmo), .err_cmd(err_cmd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (send_cmd) n_send <= n_send + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] c);
    wr_en = 1'b1;
    wr_cmd = c;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_send(input string tag);
    for (int i = 0; i < 300 && send_cmd !== 1'b1; i++) @(negedge clk);
    check({tag, "_send"}, send_cmd, 1);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 300 && done !== 1'b1; i++) @(negedge clk);
    check({tag, "_done"}, done, 1);
  endtask

  // Acts as RemoteComm: cmd_sent right on the strobe, response dly cycles later.
  task automatic run_cmd(input string tag, input logic [15:0] exp_cmd,
                         input logic [7:0] r, input int dly);
    wait_send(tag);
    check({tag, "_cmd"}, cmd, exp_cmd);
    cmd_sent = 1'b1;
    @(negedge clk);
    cmd_sent = 1'b0;
    repeat (dly - 1) @(negedge clk);
    resp = r;
    resp_rdy = 1'b1;
    @(negedge clk);
    resp_rdy = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_send", send_cmd, 0);
    check("rst_cmd", cmd, 0);
    check("rst_npass", n_pass, 0);

    // T1: reset while waiting on the second command's reply
    push(16'h1001); push(16'h1002); push(16'h1003);
    pulse_start();
    run_cmd("t1a", 16'h1001, 8'hA5, 3);
    wait_send("t1b");
    cmd_sent = 1'b1;
    @(negedge clk);
    cmd_sent = 1'b0;
    repeat (3) @(negedge clk);
    check("t1_busy_pre", busy, 1);
    check("t1_npass_pre", n_pass, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t1_busy", busy, 0);
    check("t1_empty", empty, 1);
    check("t1_npass", n_pass, 0);
    check("t1_send", send_cmd, 0);
    check("t1_done", done, 0);
    check("t1_cmd", cmd, 0);

    // T2: single calibrate command, ACK 40 cycles after cmd_sent
    push(16'h2000);
    snap = n_send;
    pulse_start();
    run_cmd("t2", 16'h2000, 8'hA5, 40);
    wait_done("t2");
    check("t2_npass", n_pass, 1);
    check("t2_nfail", n_fail, 0);
    check("t2_empty", empty, 1);
    check("t2_busy", busy, 0);
    check("t2_sends", n_send - snap, 1);

    // T3: no response; n_tmo rises exactly 50 cycles after send_cmd
    push(16'h3003);
    pulse_start();
    check("t3_cleared", n_pass, 0);
    wait_send("t3");
    cmd_sent = 1'b1;
    @(negedge clk);
    cmd_sent = 1'b0;
    repeat (48) @(negedge clk);
    check("t3_ntmo_49", n_tmo, 0);
    @(negedge clk);
    check("t3_ntmo_50", n_tmo, 1);
    check("t3_errcmd", err_cmd, 16'h3003);
    check("t3_nfail", n_fail, 0);
    wait_done("t3");

    // T4: ACK / NAK / ACK
    push(16'h4001); push(16'h4002); push(16'h4003);
    pulse_start();
    check("t4_ntmo_clr", n_tmo, 0);
    run_cmd("t4a", 16'h4001, 8'hA5, 5);
    run_cmd("t4b", 16'h4002, 8'h5A, 5);
`ifdef STOP_ON_ERR_EN
    wait_done("t4_stop");
    check("t4_stop_npass", n_pass, 1);
    check("t4_stop_nfail", n_fail, 1);
    check("t4_stop_err", err_cmd, 16'h4002);
    check("t4_stop_empty", empty, 0);
    pulse_start();
    run_cmd("t4c", 16'h4003, 8'hA5, 5);
    wait_done("t4_resume");
    check("t4_res_npass", n_pass, 1);
    check("t4_res_nfail", n_fail, 0);
    check("t4_res_empty", empty, 1);
`else
    run_cmd("t4c", 16'h4003, 8'hA5, 5);
    wait_done("t4");
    check("t4_npass", n_pass, 2);
    check("t4_nfail", n_fail, 1);
    check("t4_err", err_cmd, 16'h4002);
    check("t4_ntmo", n_tmo, 0);
`endif

    // T5: fill, overflow drop, push+pop at full, ordering across wrap
    for (int i = 0; i < 9; i++) begin
      push(16'hB000 + 16'(i));
      if (i == 6) check("t5_notfull7", full, 0);
      if (i == 7) check("t5_full8", full, 1);
    end
    check("t5_full9", full, 1);
    check("t5_empty9", empty, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b1;
    wr_cmd = 16'hB0FF;
    @(negedge clk);
    wr_en = 1'b0;
    check("t5_full_pp", full, 1);
    for (int i = 0; i < 8; i++) run_cmd("t5a", 16'hB000 + 16'(i), 8'hA5, 2);
    run_cmd("t5a_last", 16'hB0FF, 8'hA5, 2);
    wait_done("t5a");
    check("t5a_npass", n_pass, 9);
    for (int i = 0; i < 8; i++) push(16'hC000 + 16'(i));
    check("t5b_full", full, 1);
    pulse_start();
    for (int i = 0; i < 8; i++) run_cmd("t5b", 16'hC000 + 16'(i), 8'hA5, 2);
    wait_done("t5b");
    for (int i = 0; i < 4; i++) push(16'hD000 + 16'(i));
    pulse_start();
    for (int i = 0; i < 4; i++) run_cmd("t5c", 16'hD000 + 16'(i), 8'hA5, 2);
    wait_done("t5c");
    check("t5c_npass", n_pass, 4);
    check("t5c_empty", empty, 1);

    // T6: start on empty script, then stray responses while idle
    snap = n_send;
    pulse_start();
    wait_done("t6");
    check("t6_sends", n_send - snap, 0);
    check("t6_npass", n_pass, 0);
    resp = 8'hA5;
    resp_rdy = 1'b1;
    @(negedge clk);
    resp = 8'h00;
    @(negedge clk);
    resp_rdy = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_stray_pass", n_pass, 0);
    check("t6_stray_fail", n_fail, 0);
    check("t6_stray_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
